// File: rtl/password_cracker_array_if.sv
// Host-side bundle for the password cracker array:
// start/target in, status and result out.
interface password_cracker_array_if #(
  parameter int PW_LEN = 4,
  parameter int CNT_W  = 32
);
  logic                  start;
  logic [PW_LEN*8-1:0]   password_to_crack;
  logic                  busy;
  logic                  found;
  logic                  done;
  logic [PW_LEN*8-1:0]   found_password;
  logic [5:0]            found_engine;
  logic [CNT_W-1:0]      cycle_count;

  modport master (
    output start,
    output password_to_crack,
    input  busy,
    input  found,
    input  done,
    input  found_password,
    input  found_engine,
    input  cycle_count
  );

  modport slave (
    input  start,
    input  password_to_crack,
    output busy,
    output found,
    output done,
    output found_password,
    output found_engine,
    output cycle_count
  );
endinterface

// File: rtl/password_cracker_array.sv
// Parallel brute-force password search; each engine
// sweeps one slice of the first-character range.
module password_cracker_array #(
  parameter int NUM_ENGINES  = 9,
  parameter int PW_LEN       = 4,
  parameter int CHARSET_SIZE = 36,
  parameter int CNT_W        = 32
) (
  input  logic clk,
  input  logic rst,
  password_cracker_array_if.slave bus
);
  localparam int IW = 6;
  localparam int PW = PW_LEN * 8;
  localparam int SLICE =
    (CHARSET_SIZE + NUM_ENGINES - 1) / NUM_ENGINES;
  localparam logic [IW-1:0] LAST = IW'(CHARSET_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                 r_st;
  state_t                 w_st_nxt;
  logic [PW-1:0]          r_target;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_found;
  logic [PW-1:0]          r_fpw;
  logic [5:0]             r_feng;

  logic                   w_load;
  logic                   w_step;
  logic                   w_any;
  logic [NUM_ENGINES-1:0] w_hit;
  logic [NUM_ENGINES-1:0] w_fin;
  logic [PW-1:0]          w_cand [NUM_ENGINES];
  logic [PW-1:0]          w_pw;
  logic [5:0]             w_win;

  function automatic logic [7:0] idx2asc(
    input logic [IW-1:0] i
  );
    if (i < IW'(26)) return {2'b00, i} + 8'h61;
    return {2'b00, i} + 8'h16;
  endfunction

  assign w_load = bus.start && (r_st != S_RUN);
  assign w_step = (r_st == S_RUN);

  for (genvar e = 0; e < NUM_ENGINES; e++) begin : g_eng
    localparam int LO = e * SLICE;
    localparam int HI_X =
      ((e + 1) * SLICE < CHARSET_SIZE) ?
      (e + 1) * SLICE : CHARSET_SIZE;
    localparam bit EMPTY = (LO >= CHARSET_SIZE);
    localparam logic [IW-1:0] LO_I =
      EMPTY ? '0 : IW'(LO);
    localparam logic [IW-1:0] HI_I =
      EMPTY ? '0 : IW'(HI_X - 1);

    logic [IW-1:0] r_idx [PW_LEN];
    logic [IW-1:0] w_nxt [PW_LEN];
    logic          r_act;
    logic          w_last;
    logic          w_carry;
    logic [PW-1:0] w_str;

    // Candidate string and end-of-slice detection
    always_comb begin
      w_str  = '0;
      w_last = 1'b1;
      for (int c = 0; c < PW_LEN; c++) begin
        w_str[(PW_LEN-1-c)*8 +: 8] = idx2asc(r_idx[c]);
        if (c == 0) begin
          if (r_idx[0] != HI_I) w_last = 1'b0;
        end else begin
          if (r_idx[c] != LAST) w_last = 1'b0;
        end
      end
    end

    // Odometer step, last character fastest
    always_comb begin
      w_nxt   = r_idx;
      w_carry = 1'b1;
      for (int c = PW_LEN - 1; c >= 0; c--) begin
        if (w_carry) begin
          if (r_idx[c] == LAST) begin
            w_nxt[c] = '0;
          end else begin
            w_nxt[c] = r_idx[c] + 1'b1;
            w_carry  = 1'b0;
          end
        end
      end
    end

    // Engine state: load on start, advance while running
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_act <= 1'b0;
        for (int c = 0; c < PW_LEN; c++)
          r_idx[c] <= '0;
      end else if (w_load) begin
        r_act <= !EMPTY;
        for (int c = 0; c < PW_LEN; c++)
          r_idx[c] <= (c == 0) ? LO_I : '0;
      end else if (w_step && r_act) begin
        if (w_last) begin
          r_act <= 1'b0;
        end else begin
          for (int c = 0; c < PW_LEN; c++)
            r_idx[c] <= w_nxt[c];
        end
      end
    end

    assign w_cand[e] = w_str;
    assign w_hit[e]  = r_act && (w_str == r_target);
    assign w_fin[e]  = !r_act || w_last;
  end

  // Lowest-index hit wins
  always_comb begin
    w_any = |w_hit;
    w_win = '0;
    w_pw  = '0;
    for (int e = NUM_ENGINES - 1; e >= 0; e--) begin
      if (w_hit[e]) begin
        w_win = 6'(e);
        w_pw  = w_cand[e];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_st <= S_IDLE;
    else      r_st <= w_st_nxt;
  end

  // FSM next-state
  always_comb begin
    w_st_nxt = r_st;
    unique case (r_st)
      S_IDLE, S_DONE: begin
        if (bus.start) w_st_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_any || (&w_fin)) w_st_nxt = S_DONE;
      end
      default: w_st_nxt = S_IDLE;
    endcase
  end

  // Target latch, cycle counter and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_target <= '0;
      r_cnt    <= '0;
      r_found  <= 1'b0;
      r_fpw    <= '0;
      r_feng   <= '0;
    end else if (w_load) begin
      r_target <= bus.password_to_crack;
      r_cnt    <= '0;
      r_found  <= 1'b0;
      r_fpw    <= '0;
      r_feng   <= '0;
    end else if (w_step) begin
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      if (w_any) begin
        r_found <= 1'b1;
        r_fpw   <= w_pw;
        r_feng  <= w_win;
      end
    end
  end

  assign bus.busy           = (r_st == S_RUN);
  assign bus.done           = (r_st == S_DONE);
  assign bus.found          = r_found;
  assign bus.found_password = r_fpw;
  assign bus.found_engine   = r_feng;
  assign bus.cycle_count    = r_cnt;
endmodule

// File: tb/tb_password_cracker_array.sv
// Directed bench: two array configurations (9 and 5
// engines, 2-char passwords) with hand-computed results.
module tb_password_cracker_array;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;
  int   n;

  always #5 clk = ~clk;

  password_cracker_array_if #(.PW_LEN(2), .CNT_W(32)) if0();
  password_cracker_array_if #(.PW_LEN(2), .CNT_W(32)) if1();

  password_cracker_array #(
    .NUM_ENGINES(9), .PW_LEN(2),
    .CHARSET_SIZE(36), .CNT_W(32)
  ) u0 (
    .clk(clk), .rst(rst), .bus(if0)
  );

  password_cracker_array #(
    .NUM_ENGINES(5), .PW_LEN(2),
    .CHARSET_SIZE(36), .CNT_W(32)
  ) u1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic start0(input logic [15:0] pw);
    @(negedge clk);
    if0.start = 1'b1;
    if0.password_to_crack = pw;
    @(negedge clk);
    if0.start = 1'b0;
  endtask

  task automatic start1(input logic [15:0] pw);
    @(negedge clk);
    if1.start = 1'b1;
    if1.password_to_crack = pw;
    @(negedge clk);
    if1.start = 1'b0;
  endtask

  task automatic wait0(output int cyc);
    cyc = 0;
    while (!if0.done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait1(output int cyc);
    cyc = 0;
    while (!if1.done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    if0.start = 1'b0;
    if0.password_to_crack = '0;
    if1.start = 1'b0;
    if1.password_to_crack = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy",  64'(if0.busy), 64'd0);
    chk("rst_found", 64'(if0.found), 64'd0);
    chk("rst_done",  64'(if0.done), 64'd0);
    chk("rst_fpw",   64'(if0.found_password), 64'd0);
    chk("rst_feng",  64'(if0.found_engine), 64'd0);
    chk("rst_cnt",   64'(if0.cycle_count), 64'd0);
    chk("rst_done1", 64'(if1.done), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // "ab": engine 0, second candidate
    start0(16'h6162);
    chk("ab_busy", 64'(if0.busy), 64'd1);
    wait0(n);
    chk("ab_wait",  64'(n), 64'd2);
    chk("ab_done",  64'(if0.done), 64'd1);
    chk("ab_busy0", 64'(if0.busy), 64'd0);
    chk("ab_found", 64'(if0.found), 64'd1);
    chk("ab_fpw",   64'(if0.found_password), 64'h6162);
    chk("ab_feng",  64'(if0.found_engine), 64'd0);
    chk("ab_cnt",   64'(if0.cycle_count), 64'd2);

    // "z9": engine 6; a start pulse mid-run is ignored
    start0(16'h7A39);
    repeat (10) @(negedge clk);
    start0(16'h6162);
    chk("z9_busy", 64'(if0.busy), 64'd1);
    wait0(n);
    chk("z9_found", 64'(if0.found), 64'd1);
    chk("z9_fpw",   64'(if0.found_password), 64'h7A39);
    chk("z9_feng",  64'(if0.found_engine), 64'd6);
    chk("z9_cnt",   64'(if0.cycle_count), 64'd72);

    // DONE holds
    repeat (5) @(negedge clk);
    chk("hold_done", 64'(if0.done), 64'd1);
    chk("hold_feng", 64'(if0.found_engine), 64'd6);
    chk("hold_cnt",  64'(if0.cycle_count), 64'd72);
    chk("hold_busy", 64'(if0.busy), 64'd0);

    // "ca" started straight from DONE
    start0(16'h6361);
    chk("ca_clr", 64'(if0.found), 64'd0);
    wait0(n);
    chk("ca_found", 64'(if0.found), 64'd1);
    chk("ca_fpw",   64'(if0.found_password), 64'h6361);
    chk("ca_feng",  64'(if0.found_engine), 64'd0);
    chk("ca_cnt",   64'(if0.cycle_count), 64'd73);

    // "A1": out of alphabet, exhaustion
    start0(16'h4131);
    wait0(n);
    chk("A1_wait",  64'(n), 64'd144);
    chk("A1_done",  64'(if0.done), 64'd1);
    chk("A1_found", 64'(if0.found), 64'd0);
    chk("A1_fpw",   64'(if0.found_password), 64'd0);
    chk("A1_feng",  64'(if0.found_engine), 64'd0);
    chk("A1_cnt",   64'(if0.cycle_count), 64'd144);

    // reset at cycle 50 of an "A1" search
    start0(16'h4131);
    repeat (50) @(negedge clk);
    chk("mid_cnt", 64'(if0.cycle_count), 64'd50);
    rst = 1'b0;
    #1;
    chk("mr_busy",  64'(if0.busy), 64'd0);
    chk("mr_done",  64'(if0.done), 64'd0);
    chk("mr_found", 64'(if0.found), 64'd0);
    chk("mr_cnt",   64'(if0.cycle_count), 64'd0);
    chk("mr_fpw",   64'(if0.found_password), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    start0(16'h6162);
    wait0(n);
    chk("rs_found", 64'(if0.found), 64'd1);
    chk("rs_fpw",   64'(if0.found_password), 64'h6162);
    chk("rs_feng",  64'(if0.found_engine), 64'd0);
    chk("rs_cnt",   64'(if0.cycle_count), 64'd2);

    // 5 engines, uneven last slice 32..35: "99"
    start1(16'h3939);
    wait1(n);
    chk("99_found", 64'(if1.found), 64'd1);
    chk("99_fpw",   64'(if1.found_password), 64'h3939);
    chk("99_feng",  64'(if1.found_engine), 64'd4);
    chk("99_cnt",   64'(if1.cycle_count), 64'd144);

    // 5 engines exhaustion: 8*36
    start1(16'h4131);
    wait1(n);
    chk("x5_done",  64'(if1.done), 64'd1);
    chk("x5_found", 64'(if1.found), 64'd0);
    chk("x5_cnt",   64'(if1.cycle_count), 64'd288);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
